// File: rtl/seg7_pkg.sv
// Shared definitions for the seven-segment animator: segment bit positions,
// animation modes and row selection codes.
package seg7_pkg;

    localparam int SEG_A  = 0;
    localparam int SEG_B  = 1;
    localparam int SEG_C  = 2;
    localparam int SEG_D  = 3;
    localparam int SEG_E  = 4;
    localparam int SEG_F  = 5;
    localparam int SEG_G  = 6;
    localparam int SEG_DP = 7;

    typedef enum logic [1:0] {
        MODE_CIRCLE = 2'd0,
        MODE_WALK   = 2'd1,
        MODE_BOUNCE = 2'd2
    } mode_e;

    typedef enum logic [1:0] {
        ROW_A     = 2'd0,
        ROW_G     = 2'd1,
        ROW_D     = 2'd2,
        ROW_A_ALT = 2'd3
    } row_e;

    // Segment used by the walk/bounce modes for a given row code.
    function automatic int row_segment(input logic [1:0] row);
        case (row)
            ROW_G:   row_segment = SEG_G;
            ROW_D:   row_segment = SEG_D;
            default: row_segment = SEG_A;
        endcase
    endfunction

endpackage

// File: rtl/seg7_frame_decode.sv
// Combinational map from the animation state to an active-high segment frame
// covering every digit; the head and its trailing tail are lit.
module seg7_frame_decode
    import seg7_pkg::*;
#(
    parameter int NUM_OF_DISPLAYS = 6,
    parameter int POS_W           = 4
) (
    input  mode_e                            mode,
    input  logic [1:0]                       row,
    input  logic [POS_W-1:0]                 pos,
    input  logic [1:0]                       tail_len,
    input  logic                             direction,
    output logic [NUM_OF_DISPLAYS-1:0][7:0]  frame
);

    localparam int N        = NUM_OF_DISPLAYS;
    localparam int P_CIRCLE = 2 * N + 4;

    logic [N*8-1:0] flat;
    int             n_lit;
    int             lit_pos;
    int             digit;
    int             seg;

    // The tail trails opposite to the direction of motion, wrapping around
    // the active track; bounce mode never shows a tail.
    always_comb begin
        flat    = '0;
        n_lit   = (mode == MODE_BOUNCE) ? 1 : int'(tail_len) + 1;
        lit_pos = 0;
        digit   = 0;
        seg     = SEG_A;
        for (int t = 0; t < 4; t++) begin
            if (t < n_lit) begin
                lit_pos = direction ? int'(pos) - t : int'(pos) + t;
                if (mode == MODE_CIRCLE) begin
                    lit_pos = (lit_pos + 4 * P_CIRCLE) % P_CIRCLE;
                    if (lit_pos < N) begin
                        digit = lit_pos;
                        seg   = SEG_A;
                    end else if (lit_pos == N) begin
                        digit = N - 1;
                        seg   = SEG_B;
                    end else if (lit_pos == N + 1) begin
                        digit = N - 1;
                        seg   = SEG_C;
                    end else if (lit_pos <= 2 * N + 1) begin
                        digit = 2 * N + 1 - lit_pos;
                        seg   = SEG_D;
                    end else if (lit_pos == 2 * N + 2) begin
                        digit = 0;
                        seg   = SEG_E;
                    end else begin
                        digit = 0;
                        seg   = SEG_F;
                    end
                end else begin
                    lit_pos = (lit_pos + 4 * N) % N;
                    digit   = lit_pos;
                    seg     = row_segment(row);
                end
                flat = flat | ((N*8)'(1) << (digit * 8 + seg));
            end
        end
    end

    assign frame = flat;

endmodule

// File: rtl/seg7_animator.sv
// Segment animator for a row of seven-segment digits: tracks the head
// position and mode, and registers the polarity-corrected frame to the pins.
module seg7_animator
    import seg7_pkg::*;
#(
    parameter int NUM_OF_DISPLAYS = 6,
    parameter bit SEG_ACTIVE      = 1'b1
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic                            overflow_i,
    input  logic                            enable_i,
    input  logic [1:0]                      mode_i,
    input  logic [1:0]                      row_i,
    input  logic                            direction_i,
    input  logic [1:0]                      tail_len_i,
    output logic [NUM_OF_DISPLAYS-1:0][7:0] seg7_o
);

    localparam int N        = NUM_OF_DISPLAYS;
    localparam int P_CIRCLE = 2 * N + 4;
    localparam int POS_W    = $clog2(P_CIRCLE);

    logic [POS_W-1:0]       pos;
    logic [POS_W-1:0]       pos_next;
    logic [POS_W-1:0]       last_pos;
    logic                   bdir;
    logic                   bdir_next;
    logic [1:0]             mode_q;
    logic                   primed;
    mode_e                  mode_eff;
    logic [N-1:0][7:0]      frame;

    always_comb begin
        case (mode_q)
            2'd1:    mode_eff = MODE_WALK;
            2'd2:    mode_eff = MODE_BOUNCE;
            default: mode_eff = MODE_CIRCLE;
        endcase
    end

    // Step logic: circle and walk wrap modulo their track length, bounce
    // reverses at either end and steps away on the same tick.
    always_comb begin
        pos_next  = pos;
        bdir_next = bdir;
        last_pos  = (mode_eff == MODE_CIRCLE) ? POS_W'(P_CIRCLE - 1) : POS_W'(N - 1);
        if (overflow_i && enable_i) begin
            if (mode_eff == MODE_BOUNCE) begin
                if (bdir) begin
                    if (pos == last_pos) begin
                        bdir_next = 1'b0;
                        pos_next  = pos - POS_W'(1);
                    end else begin
                        pos_next  = pos + POS_W'(1);
                    end
                end else begin
                    if (pos == '0) begin
                        bdir_next = 1'b1;
                        pos_next  = pos + POS_W'(1);
                    end else begin
                        pos_next  = pos - POS_W'(1);
                    end
                end
            end else if (direction_i) begin
                pos_next = (pos == last_pos) ? '0 : pos + POS_W'(1);
            end else begin
                pos_next = (pos == '0) ? last_pos : pos - POS_W'(1);
            end
        end
    end

    seg7_frame_decode #(
        .NUM_OF_DISPLAYS (N),
        .POS_W           (POS_W)
    ) u_decode (
        .mode      (mode_eff),
        .row       (row_i),
        .pos       (pos),
        .tail_len  (tail_len_i),
        .direction (direction_i),
        .frame     (frame)
    );

    // A mode switch restarts the animation and overrides any coincident tick.
    // The output stays blank for one extra edge after reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pos    <= '0;
            bdir   <= 1'b1;
            mode_q <= 2'd0;
            primed <= 1'b0;
            seg7_o <= SEG_ACTIVE ? '0 : '1;
        end else begin
            primed <= 1'b1;
            if (mode_i != mode_q) begin
                mode_q <= mode_i;
                pos    <= '0;
                bdir   <= direction_i;
            end else begin
                pos    <= pos_next;
                bdir   <= bdir_next;
            end
            if (primed) begin
                seg7_o <= SEG_ACTIVE ? frame : ~frame;
            end
        end
    end

endmodule

// File: doc/seg7_animator.md
# seg7_animator

Parametrised successor to the single-pattern walking-circle driver: animates a lit segment (with optional trailing tail) across a row of NUM_OF_DISPLAYS seven-segment digits in one of three runtime-selectable modes. Advances one step per `overflow_i` tick from the clock divider, with runtime direction, enable and tail length. Drives the board's 7-seg bank directly; no other logic sits between it and the pins.

## Interface
- NUM_OF_DISPLAYS, 6, number of digits; must be ≥ 2.
- SEG_ACTIVE, 1, segment polarity: 1 = lit is 1, 0 = lit is 0.
- clk_i  input  1  system clock.
- rst_i  input  1  reset; asynchronous, active-high.
- overflow_i  input  1  single-cycle step tick from clock_div.
- enable_i  input  1  1 = advance on tick, 0 = freeze.
- mode_i  input  2  0 = perimeter circle, 1 = row walk, 2 = row bounce, 3 = reserved (behaves as 0).
- row_i  input  2  row for modes 1/2: 0 = a, 1 = g, 2 = d, 3 = a.
- direction_i  input  1  1 = clockwise / left-to-right, 0 = reverse.
- tail_len_i  input  2  extra lit positions trailing the head (0–3).
- seg7_o  output  [NUM_OF_DISPLAYS-1:0][7:0]  per-digit segments, bit0..7 = a,b,c,d,e,f,g,dp; index 0 = leftmost digit.

## Operation
- State: head position `pos`, bounce heading `bdir`, registered copy of `mode_i`.
- Perimeter (mode 0), P = 2N+4 positions: 0..N-1 = segment a of digits 0..N-1; N = b of digit N-1; N+1 = c of digit N-1; N+2..2N+1 = d of digits N-1..0; 2N+2 = e of digit 0; 2N+3 = f of digit 0. Clockwise = increment mod P.
- Row walk (mode 1), P = N: position k = selected row segment of digit k; left-to-right = increment mod N.
- Bounce (mode 2), P = N: `bdir` starts equal to direction_i at mode entry; head moves one digit per tick; at 0 or N-1 `bdir` flips and the head steps away on the same tick (sequence 0,1,..,N-1,N-2,..,0,1..); direction_i ignored after entry; tail forced to 0.
- Tail (modes 0/1): positions pos-1..pos-tail_len_i (opposite to motion, modulo P) also lit. Tail changes take effect on the next frame without moving the head.
- dp never lit. Unlit = !SEG_ACTIVE.
- Tick with enable_i=1: advance pos. enable_i=0: pos and seg7_o hold.
- direction_i change in modes 0/1: next tick steps from current pos in new direction.
- Mode change (mode_i ≠ registered mode): pos ← 0, bdir ← direction_i, regardless of tick or enable; mode change wins over a coincident tick.
- Changing row_i: head keeps digit index, moves to the new row next frame.

## Timing
- Reset: pos = 0, bdir = 1, registered mode = 0, seg7_o = all unlit (8'h00 per digit when SEG_ACTIVE=1, 8'hFF when 0).
- pos updates on the edge sampling overflow_i=1; seg7_o is registered and reflects the new pos one clock later (latency 1 from pos, 2 edges from tick sample).
- First lit frame appears on the second rising edge after rst_i deasserts.
- Reset mid-animation: immediate blank, pos=0, asynchronous.
- Back-to-back ticks (overflow_i held high) advance one step per clock.

## Structure
- Package seg7_pkg: segment bit index constants (SEG_A..SEG_DP), mode enum (MODE_CIRCLE, MODE_WALK, MODE_BOUNCE), row enum.
- Sub-module seg7_frame_decode: combinational map from (mode, row, pos, tail, P, N) to the full segment frame; seg7_animator holds counters, mode tracking, output register and polarity inversion.

## Test plan
- N=6, mode 0, dir 1, tail 0, 16 ticks -> head visits a of digits 0..5, b5, c5, d5..d0, e0, f0, returns to a0; exactly one lit bit each frame.
- Mode 1, row 1, dir 0, tail 2, from pos 0 -> after one tick g lit on digits 5 (head), 0 and 1 (tail).
- Mode 2, dir 1, 12 ticks -> head digit sequence 1,2,3,4,5,4,3,2,1,0,1,2.
- SEG_ACTIVE=0, reset asserted mid-run -> seg7_o = 8'hFF on all digits immediately; a0 (bit0=0) two edges after release.
- Mode change coincident with tick, enable_i=0 during ticks -> pos forced to 0; frozen frame unchanged across 5 ticks.
